// File: rtl/register_file_pkg.sv
// Shared default sizing for the register file slice.
package register_file_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 3;

endpackage

// File: rtl/register_file_if.sv
// Write port and two read ports of the register file, bundled for connection.
interface register_file_if
   import register_file_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

   logic                  we;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic [DATA_WIDTH-1:0] write_data;
   logic [ADDR_WIDTH-1:0] read_addr1;
   logic [ADDR_WIDTH-1:0] read_addr2;
   logic [DATA_WIDTH-1:0] read_data1;
   logic [DATA_WIDTH-1:0] read_data2;

   modport master (
      output we, write_addr, write_data, read_addr1, read_addr2,
      input  read_data1, read_data2
   );

   modport slave (
      input  we, write_addr, write_data, read_addr1, read_addr2,
      output read_data1, read_data2
   );

endinterface

// File: rtl/register_file_read_port.sv
// One combinational read port: DEPTH:1 mux, returning zero for unimplemented indices.
module register_file_read_port
   import register_file_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH      = 1 << ADDR_WIDTH
) (
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] regs_i [DEPTH],
   output logic [DATA_WIDTH-1:0] data_o
);

   // An index at or beyond DEPTH matches no entry, so the default zero stands.
   always_comb begin
      data_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (addr_i == ADDR_WIDTH'(i)) begin
            data_o = regs_i[i];
         end
      end
   end

endmodule

// File: rtl/register_file.sv
// Register array with one synchronous write port and two independent combinational read ports.
module register_file
   import register_file_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH      = 1 << ADDR_WIDTH
) (
   input  logic            clk,
   input  logic            rst,
   register_file_if.slave  bus
);

   logic [DATA_WIDTH-1:0] regs_q [DEPTH];
   logic [DATA_WIDTH-1:0] regs_d [DEPTH];

   // Writes to indices at or beyond DEPTH decode to nothing and are dropped.
   always_comb begin
      regs_d = regs_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.we && (bus.write_addr == ADDR_WIDTH'(i))) begin
            regs_d[i] = bus.write_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   register_file_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_read_port1 (
      .addr_i (bus.read_addr1),
      .regs_i (regs_q),
      .data_o (bus.read_data1)
   );

   register_file_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_read_port2 (
      .addr_i (bus.read_addr2),
      .regs_i (regs_q),
      .data_o (bus.read_data2)
   );

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: full-depth and DEPTH=6 instances driven in lockstep against a reference array.
module tb_register_file;

   logic clk;
   logic rst;

   register_file_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus_a ();
   register_file_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus_b ();

   register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .DEPTH(8)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .DEPTH(6)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         port;
      logic [7:0] exp;
   } sb_entry_t;

   sb_entry_t  sb [$];
   logic [7:0] model [8];
   int         checks   = 0;
   int         failures = 0;

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_b(input logic [2:0] a);
      return (a >= 3'd6) ? 8'h00 : model[a];
   endfunction

   task automatic set_reads(input logic [2:0] a1, input logic [2:0] a2);
      bus_a.read_addr1 = a1;
      bus_a.read_addr2 = a2;
      bus_b.read_addr1 = a1;
      bus_b.read_addr2 = a2;
      sb.push_back('{port: 0, exp: model[a1]});
      sb.push_back('{port: 1, exp: model[a2]});
      sb.push_back('{port: 2, exp: exp_b(a1)});
      sb.push_back('{port: 3, exp: exp_b(a2)});
   endtask

   task automatic sample(input string tag);
      sb_entry_t  e;
      logic [7:0] obs;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.port)
            0:       obs = bus_a.read_data1;
            1:       obs = bus_a.read_data2;
            2:       obs = bus_b.read_data1;
            default: obs = bus_b.read_data2;
         endcase
         check_val($sformatf("%s_p%0d", tag, e.port), obs, e.exp);
      end
   endtask

   task automatic drive_write(input logic w, input logic [2:0] a, input logic [7:0] d);
      bus_a.we = w; bus_a.write_addr = a; bus_a.write_data = d;
      bus_b.we = w; bus_b.write_addr = a; bus_b.write_data = d;
   endtask

   task automatic do_write(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      drive_write(1'b1, a, d);
      @(posedge clk);
      if (!rst) model[a] = d;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      drive_write(1'b0, 3'd0, 8'h00);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) model[i] = 8'h00;
      rst = 1'b1;
      drive_write(1'b0, 3'd0, 8'h00);
      #2;
      set_reads(3'd0, 3'd0);
      sample("reset_hold");

      @(negedge clk);
      rst = 1'b0;
      for (int a = 0; a < 8; a++) begin
         set_reads(3'(a), 3'(7 - a));
         sample($sformatf("reset_scan%0d", a));
      end

      do_write(3'd3, 8'hAA);
      do_write(3'd5, 8'h55);
      idle_cycle();
      set_reads(3'd3, 3'd5);
      sample("readback_3_5");
      set_reads(3'd0, 3'd1);
      sample("readback_0_1");

      @(negedge clk);
      drive_write(1'b0, 3'd3, 8'hFF);
      repeat (3) @(posedge clk);
      @(negedge clk);
      set_reads(3'd3, 3'd3);
      sample("we_low_hold");

      @(negedge clk);
      drive_write(1'b1, 3'd6, 8'h3C);
      set_reads(3'd6, 3'd6);
      sample("collide_pre");
      @(posedge clk);
      model[6] = 8'h3C;
      set_reads(3'd6, 3'd6);
      sample("collide_post");
      idle_cycle();

      set_reads(3'd3, 3'd5);
      sample("pre_rst");
      @(negedge clk);
      drive_write(1'b1, 3'd2, 8'h77);
      #2;
      rst = 1'b1;
      for (int i = 0; i < 8; i++) model[i] = 8'h00;
      set_reads(3'd3, 3'd5);
      sample("rst_async");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive_write(1'b0, 3'd0, 8'h00);
      set_reads(3'd2, 3'd6);
      sample("rst_write_ignored");

      for (int a = 0; a < 8; a++) do_write(3'(a), 8'(a + 1));
      idle_cycle();
      for (int a = 0; a < 8; a++) begin
         set_reads(3'(a), 3'(7 - a));
         sample($sformatf("bound_scan%0d", a));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
